// File: rtl/ahb_mem_slave_if.sv
// AHB slave-side bus bundle for ahb_mem_slave: address/control, write data and response.
interface ahb_mem_slave_if;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] hwdata;
    logic [3:0]  hmaster;
    logic        hmastlock;
    logic        hready_in;
    logic        hready;
    logic [1:0]  hresp;
    logic [31:0] hrdata;

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hburst, hwdata,
               hmaster, hmastlock, hready_in,
        output hready, hresp, hrdata
    );

    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hburst, hwdata,
               hmaster, hmastlock, hready_in,
        input  hready, hresp, hrdata
    );
endinterface

// File: rtl/ahb_mem_slave.sv
// AHB 2.0 word-organised SRAM responder with programmable wait states,
// byte-lane writes and a two-cycle ERROR response for illegal accesses.
module ahb_mem_slave #(
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic             hclk,
    input  logic             hreset,
    ahb_mem_slave_if.slave   bus
);

    localparam int unsigned IDX_W     = $clog2(DEPTH);
    localparam logic [31:0] WIN_BYTES = 32'(4 * DEPTH);
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);
    localparam logic [1:0]  RESP_OKAY = 2'b00;
    localparam logic [1:0]  RESP_ERR  = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t             state, state_n;
    logic [3:0]         cnt, cnt_n;
    logic               rdy, rdy_n;
    logic [1:0]         resp, resp_n;
    logic [31:0]        rdata, rdata_n;

    // latched data-phase attributes of the current OKAY transfer
    logic               dp_valid, dp_valid_n;
    logic               dp_write, dp_write_n;
    logic [IDX_W-1:0]   dp_idx, dp_idx_n;
    logic [1:0]         dp_lane, dp_lane_n;
    logic [1:0]         dp_size, dp_size_n;

    logic [31:0]        mem [DEPTH];

    logic [31:0]        offset;
    logic               accept;
    logic               legal;
    logic               align_ok;
    logic               wr_en;
    logic [3:0]         wr_mask;
    logic [31:0]        wr_word;
    logic [31:0]        rd_word;
    logic               dbg_unused;

    assign bus.hready = rdy;
    assign bus.hresp  = resp;
    assign bus.hrdata = rdata;

    // informational bus fields that never affect behaviour
    assign dbg_unused = ^{bus.hburst, bus.hmaster, bus.hmastlock, bus.htrans[0]};

    // address-phase decode: window, size and alignment legality
    always_comb begin
        offset   = bus.haddr - ADDR_BASE;
        accept   = bus.hsel && bus.hready_in;
        align_ok = 1'b1;
        case (bus.hsize)
            3'd1:    align_ok = !bus.haddr[0];
            3'd2:    align_ok = (bus.haddr[1:0] == 2'b00);
            default: align_ok = 1'b1;
        endcase
        legal = (offset < WIN_BYTES) && (bus.hsize <= 3'd2) && align_ok;
    end

    // byte-lane merge for the write completing at the coming edge
    always_comb begin
        wr_en   = rdy && dp_valid && dp_write;
        wr_mask = 4'b1111;
        case (dp_size)
            2'd0:    wr_mask = 4'b0001 << dp_lane;
            2'd1:    wr_mask = dp_lane[1] ? 4'b1100 : 4'b0011;
            default: wr_mask = 4'b1111;
        endcase
        wr_word = mem[dp_idx];
        for (int b = 0; b < 4; b++) begin
            if (wr_mask[b]) begin
                wr_word[8*b +: 8] = bus.hwdata[8*b +: 8];
            end
        end
    end

    // next state, next registered outputs and data-phase latching
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        rdy_n      = 1'b1;
        resp_n     = RESP_OKAY;
        dp_valid_n = dp_valid;
        dp_write_n = dp_write;
        dp_idx_n   = dp_idx;
        dp_lane_n  = dp_lane;
        dp_size_n  = dp_size;
        case (state)
            ST_IDLE, ST_ERR2: begin
                state_n    = ST_IDLE;
                dp_valid_n = 1'b0;
                if (accept) begin
                    dp_write_n = bus.hwrite;
                    dp_idx_n   = offset[IDX_W+1:2];
                    dp_lane_n  = bus.haddr[1:0];
                    dp_size_n  = bus.hsize[1:0];
                    if (bus.htrans[1]) begin
                        if (!legal) begin
                            state_n = ST_ERR1;
                            rdy_n   = 1'b0;
                            resp_n  = RESP_ERR;
                        end else begin
                            dp_valid_n = 1'b1;
                            if (WAIT_INIT != 4'd0) begin
                                state_n = ST_WAIT;
                                cnt_n   = WAIT_INIT;
                                rdy_n   = 1'b0;
                            end
                        end
                    end
                end
            end
            ST_WAIT: begin
                rdy_n = 1'b0;
                cnt_n = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_n = ST_IDLE;
                    rdy_n   = 1'b1;
                end
            end
            ST_ERR1: begin
                state_n    = ST_ERR2;
                rdy_n      = 1'b1;
                resp_n     = RESP_ERR;
                dp_valid_n = 1'b0;
            end
            default: begin
                state_n    = ST_IDLE;
                dp_valid_n = 1'b0;
            end
        endcase
    end

    // read data for the next cycle, forwarding a write landing on the same word
    always_comb begin
        rd_word = (wr_en && (dp_idx == dp_idx_n)) ? wr_word : mem[dp_idx_n];
        rdata_n = (dp_valid_n && !dp_write_n) ? rd_word : 32'h0;
    end

    // state and output registers
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state    <= ST_IDLE;
            cnt      <= 4'd0;
            rdy      <= 1'b1;
            resp     <= RESP_OKAY;
            rdata    <= 32'h0;
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_idx   <= '0;
            dp_lane  <= 2'd0;
            dp_size  <= 2'd0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            rdy      <= rdy_n;
            resp     <= resp_n;
            rdata    <= rdata_n;
            dp_valid <= dp_valid_n;
            dp_write <= dp_write_n;
            dp_idx   <= dp_idx_n;
            dp_lane  <= dp_lane_n;
            dp_size  <= dp_size_n;
        end
    end

    // memory array, written at the end of the final OKAY data-phase cycle
    always_ff @(posedge hclk) begin
        if (wr_en) begin
            mem[dp_idx] <= wr_word;
        end
    end

endmodule

// File: tb/tb_ahb_mem_slave.sv
// Bench for ahb_mem_slave: two instances (zero-wait and three-wait) behind a
// small address decoder, directed transfers with a scoreboard-driven monitor.
module tb_ahb_mem_slave;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_BUSY   = 2'b01;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;
    localparam logic [1:0] OKAY     = 2'b00;
    localparam logic [1:0] ERR      = 2'b01;

    typedef struct {
        logic [1:0]  resp;
        int          waits;
        logic [31:0] data;
    } exp_t;

    logic        hclk = 1'b0;
    logic        hreset;
    logic        m_hsel;
    logic [31:0] m_haddr;
    logic [1:0]  m_htrans;
    logic        m_hwrite;
    logic [2:0]  m_hsize;
    logic [2:0]  m_hburst;
    logic [31:0] m_hwdata;
    logic        dsel;
    logic        hready_m;
    logic [1:0]  hresp_m;
    logic [31:0] hrdata_m;
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    exp_t        q[$];

    always #5 hclk = ~hclk;

    ahb_mem_slave_if bus0 ();
    ahb_mem_slave_if bus1 ();

    assign bus0.hsel      = m_hsel && !m_haddr[16];
    assign bus1.hsel      = m_hsel &&  m_haddr[16];
    assign bus0.haddr     = m_haddr;   assign bus1.haddr     = m_haddr;
    assign bus0.htrans    = m_htrans;  assign bus1.htrans    = m_htrans;
    assign bus0.hwrite    = m_hwrite;  assign bus1.hwrite    = m_hwrite;
    assign bus0.hsize     = m_hsize;   assign bus1.hsize     = m_hsize;
    assign bus0.hburst    = m_hburst;  assign bus1.hburst    = m_hburst;
    assign bus0.hwdata    = m_hwdata;  assign bus1.hwdata    = m_hwdata;
    assign bus0.hmaster   = 4'd1;      assign bus1.hmaster   = 4'd1;
    assign bus0.hmastlock = 1'b0;      assign bus1.hmastlock = 1'b0;
    assign bus0.hready_in = hready_m;  assign bus1.hready_in = hready_m;

    assign hready_m = dsel ? bus1.hready : bus0.hready;
    assign hresp_m  = dsel ? bus1.hresp  : bus0.hresp;
    assign hrdata_m = dsel ? bus1.hrdata : bus0.hrdata;

    // data-phase slave select for the response mux
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) dsel <= 1'b0;
        else if (hready_m) dsel <= m_haddr[16];
    end

    always_ff @(posedge hclk) cyc <= cyc + 1;

    ahb_mem_slave #(.ADDR_BASE(32'h0000_0000), .DEPTH(1024), .WAIT_STATES(0)) u_dut0 (
        .hclk(hclk), .hreset(hreset), .bus(bus0.slave));

    ahb_mem_slave #(.ADDR_BASE(32'h0001_0000), .DEPTH(16), .WAIT_STATES(3)) u_dut1 (
        .hclk(hclk), .hreset(hreset), .bus(bus1.slave));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // drive one address phase, wait until accepted, then present its write data
    task automatic issue(input bit sel, input logic [1:0] trans, input bit wr,
                         input logic [2:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [1:0] eresp,
                         input int ewaits, input logic [31:0] edata);
        bit ok;
        int n;
        exp_t e;
        m_hsel   = sel;
        m_htrans = trans;
        m_hwrite = wr;
        m_hsize  = size;
        m_haddr  = addr;
        if (sel) begin
            e.resp  = eresp;
            e.waits = ewaits;
            e.data  = edata;
            q.push_back(e);
        end
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 32) begin
            @(negedge hclk);
            ok = hready_m;
            @(posedge hclk);
            #1;
            n++;
        end
        check("accept", 32'(ok), 32'd1);
        m_hwdata = wdata;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data,
                      input logic [2:0] size, input int w);
        issue(1'b1, T_NONSEQ, 1'b1, size, addr, data, OKAY, w, 32'h0);
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input int w);
        issue(1'b1, T_NONSEQ, 1'b0, 3'd2, addr, 32'h0, OKAY, w, exp);
    endtask

    task automatic err(input logic [31:0] addr, input bit w, input logic [2:0] size);
        issue(1'b1, T_NONSEQ, w, size, addr, 32'hFFFF_FFFF, ERR, 1, 32'h0);
    endtask

    task automatic idle();
        issue(1'b0, T_IDLE, 1'b0, 3'd2, 32'h0, 32'h0, OKAY, 0, 32'h0);
    endtask

    // monitor: pops the expectation for each completed data phase
    initial begin : monitor
        bit   in_dp;
        int   waits;
        exp_t e;
        in_dp = 1'b0;
        waits = 0;
        forever begin
            @(negedge hclk);
            if (hreset) begin
                in_dp = 1'b0;
                waits = 0;
                q.delete();
                continue;
            end
            if (in_dp) begin
                if (q.size() == 0) begin
                    check("unexpected_phase", 32'd1, 32'd0);
                    in_dp = 1'b0;
                    waits = 0;
                end else if (!hready_m) begin
                    waits++;
                    check("wait_resp", 32'(hresp_m), 32'(q[0].resp));
                end else begin
                    e = q.pop_front();
                    check("resp", 32'(hresp_m), 32'(e.resp));
                    check("rdata", hrdata_m, e.data);
                    check("waits", 32'(waits), 32'(e.waits));
                    in_dp = 1'b0;
                    waits = 0;
                end
            end
            if (m_hsel && hready_m) in_dp = 1'b1;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin : stimulus
        int t0;
        m_hsel   = 1'b0;
        m_haddr  = 32'h0;
        m_htrans = T_IDLE;
        m_hwrite = 1'b0;
        m_hsize  = 3'd2;
        m_hburst = 3'd0;
        m_hwdata = 32'h0;
        hreset   = 1'b1;
        repeat (2) @(posedge hclk);
        #1;
        check("rst_hready0", 32'(bus0.hready), 32'd1);
        check("rst_hresp0",  32'(bus0.hresp),  32'd0);
        check("rst_hrdata0", bus0.hrdata,      32'h0);
        check("rst_hready1", 32'(bus1.hready), 32'd1);
        check("rst_hresp1",  32'(bus1.hresp),  32'd0);
        @(posedge hclk);
        #2;
        hreset = 1'b0;

        // zero-wait word write then back-to-back read
        wr(32'h10, 32'hDEAD_BEEF, 3'd2, 0);
        rd(32'h10, 32'hDEAD_BEEF, 0);

        // byte and halfword lanes
        wr(32'h10, 32'h1122_3344, 3'd2, 0);
        wr(32'h13, 32'hAA00_0000, 3'd0, 0);
        rd(32'h10, 32'hAA22_3344, 0);
        wr(32'h12, 32'h5566_0000, 3'd1, 0);
        rd(32'h10, 32'h5566_3344, 0);
        wr(32'h11, 32'h0000_7700, 3'd0, 0);
        rd(32'h10, 32'h5566_7744, 0);

        // illegal accesses leave memory untouched (0x1000 aliases word 0)
        wr(32'h0, 32'h0BAD_F00D, 3'd2, 0);
        err(32'h2, 1'b0, 3'd2);
        err(32'h2, 1'b1, 3'd2);
        err(32'h1000, 1'b1, 3'd2);
        err(32'h1, 1'b1, 3'd1);
        err(32'h0, 1'b1, 3'd3);
        rd(32'h0, 32'h0BAD_F00D, 0);

        // IDLE/BUSY while selected and NONSEQ while deselected: no access
        issue(1'b1, T_IDLE, 1'b1, 3'd2, 32'h0, 32'hFFFF_FFFF, OKAY, 0, 32'h0);
        issue(1'b1, T_BUSY, 1'b1, 3'd2, 32'h0, 32'hFFFF_FFFF, OKAY, 0, 32'h0);
        issue(1'b0, T_NONSEQ, 1'b1, 3'd2, 32'h0, 32'hFFFF_FFFF, OKAY, 0, 32'h0);
        rd(32'h0, 32'h0BAD_F00D, 0);

        // three-wait slave: single write/read
        wr(32'h1_0004, 32'hCAFE_F00D, 3'd2, 3);
        rd(32'h1_0004, 32'hCAFE_F00D, 3);

        // 4-beat INCR write burst occupies 16 data-phase cycles
        m_hburst = 3'b011;
        issue(1'b1, T_NONSEQ, 1'b1, 3'd2, 32'h1_0020, 32'h1, OKAY, 3, 32'h0);
        t0 = cyc;
        issue(1'b1, T_SEQ, 1'b1, 3'd2, 32'h1_0024, 32'h2, OKAY, 3, 32'h0);
        issue(1'b1, T_SEQ, 1'b1, 3'd2, 32'h1_0028, 32'h3, OKAY, 3, 32'h0);
        issue(1'b1, T_SEQ, 1'b1, 3'd2, 32'h1_002C, 32'h4, OKAY, 3, 32'h0);
        idle();
        check("burst_cycles", 32'(cyc - t0), 32'd16);
        issue(1'b1, T_NONSEQ, 1'b0, 3'd2, 32'h1_0020, 32'h0, OKAY, 3, 32'h1);
        issue(1'b1, T_SEQ, 1'b0, 3'd2, 32'h1_0024, 32'h0, OKAY, 3, 32'h2);
        issue(1'b1, T_SEQ, 1'b0, 3'd2, 32'h1_0028, 32'h0, OKAY, 3, 32'h3);
        issue(1'b1, T_SEQ, 1'b0, 3'd2, 32'h1_002C, 32'h0, OKAY, 3, 32'h4);
        m_hburst = 3'b001;

        // burst running off the window end errors on the offending beat
        wr(32'h1_0000, 32'h5A5A_5A5A, 3'd2, 3);
        issue(1'b1, T_NONSEQ, 1'b1, 3'd2, 32'h1_003C, 32'h0000_0099, OKAY, 3, 32'h0);
        issue(1'b1, T_SEQ, 1'b1, 3'd2, 32'h1_0040, 32'hEEEE_EEEE, ERR, 1, 32'h0);
        m_hburst = 3'b000;
        err(32'h1_0040, 1'b0, 3'd2);
        rd(32'h1_003C, 32'h0000_0099, 3);
        rd(32'h1_0000, 32'h5A5A_5A5A, 3);

        // reset in the middle of a write's wait states
        wr(32'h1_0004, 32'h1234_5678, 3'd2, 3);
        m_hsel   = 1'b0;
        m_htrans = T_IDLE;
        @(posedge hclk);
        #3;
        hreset = 1'b1;
        #1;
        check("midrst_hready", 32'(bus1.hready), 32'd1);
        check("midrst_hresp",  32'(bus1.hresp),  32'd0);
        check("midrst_hrdata", bus1.hrdata,      32'h0);
        @(posedge hclk);
        #2;
        hreset = 1'b0;
        rd(32'h1_0004, 32'hCAFE_F00D, 3);

        idle();
        repeat (3) @(posedge hclk);
        #1;
        check("queue_empty", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
